// File: rtl/burst_ram.sv
// Single-port synchronous RAM that clears itself to INIT_VAL after reset, then serves
// single or burst accesses through an auto-incrementing pointer; read data is registered with a valid strobe.
module burst_ram #(
  parameter int N = 8,
  parameter int M = 32,
  parameter logic [N-1:0] INIT_VAL = '0,
  localparam int AW = $clog2(M)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          Addr_load,
  input  logic [AW-1:0] Addr,
  input  logic          WE,
  input  logic          RE,
  input  logic          Inc,
  input  logic [N-1:0]  Data_in,
  output logic [N-1:0]  Data_out,
  output logic          Valid,
  output logic          Ready,
  output logic [AW-1:0] Ptr,
  output logic          Err
);

  localparam logic [AW-1:0] LAST = AW'(M - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t        state;
  logic [AW-1:0] idx;
  logic [N-1:0]  ram [0:M-1];

  logic          oob;
  logic [AW-1:0] ea;
  logic [AW-1:0] ptr_nxt;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_dat;

  // Out-of-range loads redirect the access to address 0 and flag Err.
  assign oob     = Addr_load && ({1'b0, Addr} >= (AW+1)'(M));
  assign ea      = oob ? '0 : (Addr_load ? Addr : Ptr);
  assign ptr_nxt = Inc ? ((ea == LAST) ? '0 : ea + AW'(1)) : ea;

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = ea;
    mem_dat  = Data_in;
    if (state == INIT) begin
      mem_we   = rst_n;
      mem_addr = idx;
      mem_dat  = INIT_VAL;
    end else begin
      mem_we   = rst_n && WE;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_dat;
  end

  // Read samples the pre-write contents, giving read-first behaviour on collisions.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= INIT;
      idx      <= '0;
      Ready    <= 1'b0;
      Ptr      <= '0;
      Valid    <= 1'b0;
      Err      <= 1'b0;
      Data_out <= '0;
    end else begin
      case (state)
        INIT: begin
          Valid <= 1'b0;
          Err   <= 1'b0;
          idx   <= idx + AW'(1);
          if (idx == LAST) begin
            state <= RUN;
            Ready <= 1'b1;
          end
        end
        RUN: begin
          Valid <= RE;
          Err   <= oob;
          Ptr   <= ptr_nxt;
          if (RE) Data_out <= ram[ea];
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: doc/burst_ram.md
# burst_ram

Parametrised single-port synchronous RAM with a hardware clear sequencer and an auto-incrementing address pointer for burst transfers. After reset it clears every location to a fixed value, then serves single or burst reads and writes through an internal pointer. It sits behind the SPI slave, so a command can load a start address once and stream consecutive bytes without re-addressing. Read data carries a one-cycle valid strobe.

## Interface
- N, 8, data width in bits
- M, 32, depth in words; any value ≥ 2, not required to be a power of two
- INIT_VAL, 0, N-bit value written to every location by the clear sequencer
- AW (localparam), $clog2(M), address width

- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- Addr_load  in  1  load Addr into pointer this cycle
- Addr  in  AW  start address, used only when Addr_load=1
- WE  in  1  write Data_in at the effective address
- RE  in  1  read the effective address
- Inc  in  1  advance the pointer after this cycle's access
- Data_in  in  N  write data
- Data_out  out  N  registered read data, held until the next read
- Valid  out  1  one-cycle strobe: Data_out updated this cycle
- Ready  out  1  high once clearing is complete; requests are accepted only while high
- Ptr  out  AW  current pointer value
- Err  out  1  one-cycle strobe: out-of-range Addr was loaded

## Operation
- States: INIT and RUN. rst_n=0 forces INIT with clear index 0. Reset values: Data_out=0, Valid=0, Ready=0, Ptr=0, Err=0.
- INIT:
  - Each cycle writes INIT_VAL to ram[idx] and increments idx.
  - On the cycle writing index M-1, the FSM moves to RUN and Ready registers high.
  - All request inputs are ignored in INIT: no writes, Valid stays 0, Ptr stays 0.
- RUN, sampled only while Ready=1:
  - Effective address ea = Addr_load ? Addr : Ptr.
  - WE=1: ram[ea] <= Data_in.
  - RE=1: Data_out <= ram[ea] and Valid=1 next cycle. Otherwise Valid=0 and Data_out holds.
  - WE and RE in the same cycle: both are performed. The read returns the old contents (read-first).
  - Next pointer: Ptr <= ea + Inc.
  - Wrap: if ea = M-1 and Inc=1, Ptr <= 0.
  - Inc with neither WE nor RE still advances the pointer (skip).
  - Addr_load with Addr ≥ M (possible only when M is not a power of two): ea is forced to 0, any access targets address 0, and Err pulses for one cycle. The next pointer is 0 + Inc.
- rst_n low mid-burst or mid-INIT: everything returns to reset values and the clear restarts from index 0. Memory contents written before reset are overwritten by the clear.

## Timing
- Edge 0 is the first rising edge with rst_n=1. Edges 0..M-1 clear addresses 0..M-1.
- Ready is high after edge M-1. The first request is accepted at edge M.
- Read latency is 1: RE sampled at edge k gives Data_out/Valid valid after edge k.
- Write is visible to a read sampled at edge k+1 or later.
- Burst throughput is one word per cycle, with no bubbles across wrap.
- Err and Valid are single-cycle pulses, registered, and never high in INIT.

## Test plan
- Reset clear, M=32: write 0xA5 everywhere. Pulse rst_n for 1 cycle, wait until Ready, read all 32 words → Ready rises exactly 32 edges after release, every read returns INIT_VAL=0x00.
- Burst write then read: Addr_load with Addr=30, then WE+Inc for 4 cycles writing 0x11,0x22,0x33,0x44. Reload 30, then RE+Inc for 4 cycles → addresses 30,31,0,1 read back 0x11..0x44 on consecutive cycles with Valid high 4 cycles; Ptr ends at 2.
- Read-first collision: ram[5]=0x55, Addr_load=1, Addr=5, WE=1, RE=1, Data_in=0xAA, Inc=0 → Data_out=0x55 with Valid=1. A following RE at Ptr=5 returns 0xAA.
- Requests during INIT: drive WE=1, RE=1, Inc=1 with Data_in=0xFF during edges 0..M-1 → Valid never asserts, Ptr=0 at Ready, all locations read INIT_VAL.
- Out-of-range load, M=24: Addr_load with Addr=27, WE=1, Data_in=0x3C, Inc=1 → Err pulses one cycle, ram[0]=0x3C, Ptr=1.
- Reset mid-burst: during a RE+Inc burst at Ptr=9, assert rst_n=0 for one cycle → next cycle Valid=0, Data_out=0, Ready=0, Ptr=0, and the clear sequence restarts from address 0.
